// File: rtl/uc_pila.sv
// Control unit for the microc datapath: opcode/zero-flag decode, with an optional return-address stack (UC_STACK_EN).
// Latency: decode is combinational in the instruction cycle; sp, stack, state and illegal update on the clk edge.
// Backpressure: valid=0 stalls with safe outputs and no side effects; a stack fault parks the FSM in HALT until reset.
module uc_pila #(
    parameter int OPW   = 6,
    parameter int OPSEL = 3,
    parameter int PCW   = 10,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic             z,
    input  logic             valid,
    input  logic [PCW-1:0]   pc_next,
    output logic             pc_en,
    output logic             s_inc,
    output logic             s_ret,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [OPSEL-1:0] op,
    output logic [PCW-1:0]   ret_addr,
    output logic [SPW-1:0]   sp,
    output logic             halted,
    output logic             illegal
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] opc;
    logic       ill_seen;

    // Only the low six opcode bits carry meaning; wider fields are folded away here.
    logic       unused_opcode;
    assign opc           = opcode[5:0];
    assign unused_opcode = ^opcode;

`ifdef UC_STACK_EN
    logic [PCW-1:0] stack [DEPTH];
    logic [SPW-1:0] sp_q;
    logic           do_push;
    logic           do_pop;
    logic           go_halt;
    logic [PCW-1:0] top;

    // Top-of-stack select written as a mux so sp's extra bit never indexes the array.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) top = stack[i];
        end
    end

    assign sp       = sp_q;
    assign ret_addr = top;
`else
    logic unused_pc_next;
    assign unused_pc_next = ^pc_next;
    assign sp             = '0;
    assign ret_addr       = '0;
`endif

    // Instruction decode; everything defaults to the safe, no-effect outputs.
    always_comb begin
        pc_en    = 1'b0;
        s_inc    = 1'b1;
        s_ret    = 1'b0;
        s_inm    = 1'b0;
        we3      = 1'b0;
        wez      = 1'b0;
        op       = '0;
        ill_seen = 1'b0;
`ifdef UC_STACK_EN
        do_push  = 1'b0;
        do_pop   = 1'b0;
        go_halt  = 1'b0;
`endif
        if (state == RUN && valid) begin
            pc_en = 1'b1;
            casez (opc)
                6'b1?????: begin
                    op  = OPSEL'(opc[4:2]);
                    we3 = 1'b1;
                    wez = 1'b1;
                end
                6'b000000: ;
                6'b0001??: begin
                    s_inm = 1'b1;
                    we3   = 1'b1;
                end
                6'b010000: s_inc = 1'b0;
                6'b010001: s_inc = ~z;
                6'b010010: s_inc = z;
`ifdef UC_STACK_EN
                6'b010011: begin
                    s_inc = 1'b0;
                    if (sp_q == SPW'(DEPTH)) begin
                        pc_en   = 1'b0;
                        go_halt = 1'b1;
                    end else begin
                        do_push = 1'b1;
                    end
                end
                6'b010100: begin
                    if (sp_q == '0) begin
                        pc_en   = 1'b0;
                        go_halt = 1'b1;
                    end else begin
                        s_ret  = 1'b1;
                        do_pop = 1'b1;
                    end
                end
`endif
                default: ill_seen = 1'b1;
            endcase
        end
    end

    // Sequencer: one BOOT cycle after reset, then RUN until a stack fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= RUN;
`ifdef UC_STACK_EN
                RUN:     state <= go_halt ? HALT : RUN;
`else
                RUN:     state <= RUN;
`endif
                default: state <= HALT;
            endcase
        end
    end

    // Sticky illegal-opcode flag, only raised by an executed instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else if (ill_seen) begin
            illegal <= 1'b1;
        end
    end

`ifdef UC_STACK_EN
    // Return-address stack: push writes the free slot at sp, pop just retreats sp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp_q == SPW'(i)) stack[i] <= pc_next;
            end
            sp_q <= sp_q + 1'b1;
        end else if (do_pop) begin
            sp_q <= sp_q - 1'b1;
        end
    end
`endif

    assign halted = (state == HALT);

endmodule

// File: tb/tb_uc_pila.sv
module tb_uc_pila;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       z;
    logic       valid;
    logic [9:0] pc_next;
    logic       pc_en, s_inc, s_ret, s_inm, we3, wez, halted, illegal;
    logic [2:0] op;
    logic [9:0] ret_addr;
    logic [2:0] sp;

    int checks   = 0;
    int failures = 0;

    uc_pila #(.OPW(6), .OPSEL(3), .PCW(10), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .z        (z),
        .valid    (valid),
        .pc_next  (pc_next),
        .pc_en    (pc_en),
        .s_inc    (s_inc),
        .s_ret    (s_ret),
        .s_inm    (s_inm),
        .we3      (we3),
        .wez      (wez),
        .op       (op),
        .ret_addr (ret_addr),
        .sp       (sp),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one instruction at the falling edge; it executes on the next rising edge.
    task automatic drive(input logic [5:0] o, input logic zz, input logic v, input logic [9:0] pn);
        @(negedge clk);
        opcode  = o;
        z       = zz;
        valid   = v;
        pc_next = pn;
        #1;
    endtask

    task automatic chk_safe(input string tag);
        chk({tag, ".pc_en"}, pc_en, 1'b0);
        chk({tag, ".we3"},   we3,   1'b0);
        chk({tag, ".wez"},   wez,   1'b0);
        chk({tag, ".s_inc"}, s_inc, 1'b1);
        chk({tag, ".s_ret"}, s_ret, 1'b0);
        chk({tag, ".s_inm"}, s_inm, 1'b0);
        chk({tag, ".op"},    op,    3'd0);
    endtask

    initial begin
        reset = 1'b0; opcode = '0; z = 1'b0; valid = 1'b0; pc_next = '0;
        repeat (2) @(negedge clk);
        opcode = 6'b100100; valid = 1'b1;
        #1;
        chk_safe("in_reset");
        chk("in_reset.sp", sp, 3'd0);
        chk("in_reset.halted", halted, 1'b0);
        chk("in_reset.illegal", illegal, 1'b0);
        reset = 1'b1;
        #1;
        chk_safe("boot");
        // First RUN cycle: ALU op 100100 -> op=001
        drive(6'b100100, 1'b0, 1'b1, 10'h000);
        chk("alu1.pc_en", pc_en, 1'b1);
        chk("alu1.op",    op,    3'b001);
        chk("alu1.we3",   we3,   1'b1);
        chk("alu1.wez",   wez,   1'b1);
        chk("alu1.s_inc", s_inc, 1'b1);
        drive(6'b111100, 1'b0, 1'b1, 10'h000);
        chk("alu7.op", op, 3'b111);
        drive(6'b000101, 1'b0, 1'b1, 10'h000);
        chk("li.s_inm", s_inm, 1'b1);
        chk("li.we3",   we3,   1'b1);
        chk("li.wez",   wez,   1'b0);
        chk("li.op",    op,    3'd0);
        drive(6'b010000, 1'b0, 1'b1, 10'h000);
        chk("j.s_inc", s_inc, 1'b0);
        chk("j.pc_en", pc_en, 1'b1);
        drive(6'b010001, 1'b1, 1'b1, 10'h000);
        chk("jz_z1.s_inc", s_inc, 1'b0);
        chk("jz_z1.we", {we3, wez}, 2'b00);
        drive(6'b010001, 1'b0, 1'b1, 10'h000);
        chk("jz_z0.s_inc", s_inc, 1'b1);
        chk("jz_z0.we", {we3, wez}, 2'b00);
        drive(6'b010010, 1'b1, 1'b1, 10'h000);
        chk("jnz_z1.s_inc", s_inc, 1'b1);
        chk("jnz_z1.we", {we3, wez}, 2'b00);
        drive(6'b010010, 1'b0, 1'b1, 10'h000);
        chk("jnz_z0.s_inc", s_inc, 1'b0);
        chk("jnz_z0.we", {we3, wez}, 2'b00);
        // Stall: a jal and an undefined opcode held with valid=0 do nothing
        for (int i = 0; i < 3; i++) begin
            drive(6'b010011, 1'b0, 1'b0, 10'h012);
            chk_safe("stall_jal");
            chk("stall_jal.sp", sp, 3'd0);
        end
        drive(6'b011111, 1'b0, 1'b0, 10'h000);
        chk("stall_ill.illegal", illegal, 1'b0);
        drive(6'b011111, 1'b0, 1'b1, 10'h000);
        chk("ill.pc_en", pc_en, 1'b1);
        chk("ill.s_inc", s_inc, 1'b1);
        chk("ill.we", {we3, wez}, 2'b00);
        chk("ill.before_edge", illegal, 1'b0);
        drive(6'b000000, 1'b0, 1'b1, 10'h000);
        chk("ill.sticky1", illegal, 1'b1);
        drive(6'b100000, 1'b0, 1'b1, 10'h000);
        chk("ill.sticky2", illegal, 1'b1);
`ifdef UC_STACK_EN
        drive(6'b010011, 1'b0, 1'b1, 10'h012);
        chk("jal.s_inc", s_inc, 1'b0);
        chk("jal.pc_en", pc_en, 1'b1);
        drive(6'b010100, 1'b0, 1'b1, 10'h000);
        chk("jal.sp", sp, 3'd1);
        chk("jal.ret_addr", ret_addr, 10'h012);
        chk("ret.s_ret", s_ret, 1'b1);
        chk("ret.pc_en", pc_en, 1'b1);
        drive(6'b000000, 1'b0, 1'b1, 10'h000);
        chk("ret.sp", sp, 3'd0);
        chk("ret.ret_addr", ret_addr, 10'h000);
        drive(6'b010011, 1'b0, 1'b1, 10'h020);
        drive(6'b010011, 1'b0, 1'b1, 10'h021);
        drive(6'b100100, 1'b0, 1'b1, 10'h000);
        chk("two_jal.sp", sp, 3'd2);
        chk("two_jal.ret_addr", ret_addr, 10'h021);
`else
        // Without the stack, jal/ret are illegal nops
        drive(6'b010011, 1'b0, 1'b1, 10'h012);
        chk("nojal.s_inc", s_inc, 1'b1);
        chk("nojal.pc_en", pc_en, 1'b1);
        drive(6'b010100, 1'b0, 1'b1, 10'h000);
        chk("nojal.sp", sp, 3'd0);
        chk("nojal.ret_addr", ret_addr, 10'h000);
        chk("noret.s_ret", s_ret, 1'b0);
        chk("noret.pc_en", pc_en, 1'b1);
        drive(6'b100100, 1'b0, 1'b1, 10'h000);
        chk("noret.halted", halted, 1'b0);
`endif
        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("arst.pc_en", pc_en, 1'b0);
        chk("arst.sp", sp, 3'd0);
        chk("arst.illegal", illegal, 1'b0);
        chk("arst.ret_addr", ret_addr, 10'h000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reboot.pc_en", pc_en, 1'b0);
        drive(6'b100100, 1'b0, 1'b1, 10'h000);
        chk("rerun.pc_en", pc_en, 1'b1);
        chk("rerun.op", op, 3'b001);
`ifdef UC_STACK_EN
        for (int i = 0; i < 4; i++) drive(6'b010011, 1'b0, 1'b1, 10'h100 + 10'(i));
        chk("ovf.pc_en", pc_en, 1'b1);
        drive(6'b010011, 1'b0, 1'b1, 10'h1ff);
        chk("ovf.sp_full", sp, 3'd4);
        chk("ovf.fault_pc_en", pc_en, 1'b0);
        chk("ovf.not_yet_halted", halted, 1'b0);
        drive(6'b100100, 1'b0, 1'b1, 10'h000);
        chk("ovf.halted", halted, 1'b1);
        chk("ovf.sp_held", sp, 3'd4);
        chk("ovf.ret_addr", ret_addr, 10'h103);
        chk_safe("halt");
        drive(6'b100100, 1'b0, 1'b1, 10'h000);
        chk("halt.stays", halted, 1'b1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uc_pila.md
# uc_pila

Parametrised control unit for the `microc` single-cycle datapath. It decodes the 6-bit opcode and zero flag into datapath selects and write enables, as the previous control unit did. It adds an internal return-address stack for `jal`/`ret`, an instruction-valid stall input, illegal-opcode detection and a halt state on stack faults. It sits between instruction memory and the `microc` datapath and also drives the PC load enable.

## Interface
Parameters:
- `OPW`, 6, opcode width; bits [5:0] are decoded, any extra MSBs are ignored.
- `OPSEL`, 3, ALU operation select width.
- `PCW`, 10, program counter width.
- `DEPTH`, 4, return-address stack entries (≥1).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  OPW  current instruction opcode field.
- `z`  in  1  registered zero flag from the datapath.
- `valid`  in  1  instruction word valid this cycle.
- `pc_next`  in  PCW  PC+1 from the datapath; this is the pushed return address.
- `pc_en`  out  1  PC register load enable.
- `s_inc`  out  1  PC source: 1 = PC+1, 0 = jump target.
- `s_ret`  out  1  PC source override: 1 = `ret_addr`.
- `s_inm`  out  1  write-data source: 1 = immediate.
- `we3`  out  1  register-file write enable.
- `wez`  out  1  zero-flag write enable.
- `op`  out  OPSEL  ALU operation.
- `ret_addr`  out  PCW  top of stack, `stack[sp-1]`; 0 when `sp`=0.
- `sp`  out  clog2(DEPTH+1)  stack occupancy.
- `halted`  out  1  the block is in HALT.
- `illegal`  out  1  sticky; an undefined opcode was seen in RUN.

## Operation
- FSM states:
  - BOOT: the reset state. Unconditionally moves to RUN on the next edge.
  - RUN: executes instructions.
  - HALT: entered on stack overflow or underflow. It is left only by reset.
- Safe outputs apply in BOOT, in HALT, and in RUN with `valid`=0: `pc_en`=0, `we3`=0, `wez`=0, `s_inc`=1, `s_ret`=0, `s_inm`=0, `op`=0. No stack change occurs.
- Decode in RUN with `valid`=1 (`pc_en`=1 unless stated otherwise):
  - `1xxxxx` ALU: `op`=opcode[4:2]; `we3`=1, `wez`=1, `s_inc`=1.
  - `000000` nop: `s_inc`=1.
  - `0001xx` li: `s_inm`=1, `we3`=1, `s_inc`=1.
  - `010000` j: `s_inc`=0.
  - `010001` jz: `s_inc`=~z.
  - `010010` jnz: `s_inc`=z.
  - `010011` jal: `s_inc`=0; push `pc_next`.
  - `010100` ret: `s_ret`=1; pop.
  - Anything else: treated as nop and sets `illegal`.
- Push: `stack[sp]` ← `pc_next`, then `sp`+1.
- Pop: `sp`−1.
- Push when `sp`=DEPTH is overflow:
  - No write occurs, `pc_en`=0, next state is HALT.
- Pop when `sp`=0 is underflow:
  - `pc_en`=0, `s_ret`=0, next state is HALT.
- `sp` never wraps.

## Timing
- Decode outputs are combinational from `opcode`, `z`, `valid` and the state. This is zero-latency, the same cycle as the instruction.
- `sp`, stack contents, state and `illegal` update on the rising `clk` edge.
- `ret_addr` reflects the new top of stack one cycle after a push or pop.
- A `ret` immediately after a `jal` returns `pc_next` of that `jal`.
- Reset assertion is asynchronous, including mid-operation. It immediately gives:
  - state BOOT, `sp`=0, `illegal`=0, `halted`=0, safe outputs.
  - Stack contents are cleared to 0.
- Deassertion is followed by exactly one BOOT cycle, then RUN.
- `valid` may drop on any cycle. A stalled instruction has no side effects and is executed in full when `valid` returns.
- `halted`=1 from the first cycle in HALT onward.

## Configuration
- `UC_STACK_EN` defined:
  - The stack, `jal` and `ret` are implemented as described above.
- `UC_STACK_EN` undefined:
  - `010011` and `010100` decode as illegal (nop, `illegal` set).
  - `sp` is tied to 0 and `ret_addr` to 0.
  - `s_ret` is tied to 0.
  - HALT is unreachable.

## Test plan
- Reset then run: `reset` low 2 cycles, release → 1 BOOT cycle with `pc_en`=0, then RUN. Opcode `100100` gives `op`=001, `we3`=`wez`=`pc_en`=1.
- Conditional jumps: `jz` with `z`=1 → `s_inc`=0; with `z`=0 → `s_inc`=1. `jnz` gives the inverse. `we3`=`wez`=0 in all four cases.
- Call/return: `jal` with `pc_next`=0x012 → `sp`=1, `ret_addr`=0x012. Then `ret` → `s_ret`=1 in that cycle, `sp`=0 next.
- Overflow, DEPTH=4: 5 consecutive `jal` → `sp` stops at 4. The 5th has `pc_en`=0 and `halted`=1 next cycle, with safe outputs until reset.
- Stall and illegal: `valid`=0 on a `jal` for 3 cycles → `sp` unchanged, `pc_en`=0. Opcode `011111` → nop behaviour and `illegal`=1, held until reset.
- Async reset mid-run with `sp`=2: `reset` low between edges → `sp`=0 and `pc_en`=0 immediately, without waiting for `clk`.
